// File: rtl/event_code_decoder.sv
// Event code decoder: buffers 3-bit event codes in a small FIFO and replays
// each one as a one-hot pulse held for HOLD_CYCLES, followed by GAP_CYCLES idle.
module event_code_decoder #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [2:0]               in_code,
    output logic                     in_ready,
    output logic [7:0]               out_onehot,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q, level_d;
    logic          full_q;
    logic          ovf_q;
    logic          push, pop;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    onehot_q, onehot_d;

    // Full is a registered flag, so a pop in the same cycle cannot open a slot.
    assign in_ready   = !full_q;
    assign push       = in_valid && !full_q;
    assign out_onehot = onehot_q;
    assign overflow   = ovf_q;
    assign level      = level_q;
    assign busy       = (state_q != IDLE) || (level_q != '0);

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; data needs no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_code;
    end

    // FIFO pointers, occupancy, full flag and the dropped-event pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
            ovf_q   <= in_valid && full_q;
        end
    end

    // Pulse sequencer state, counter and registered one-hot output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
        end
    end

    // Next-state logic: IDLE pops a code, HOLD stretches it, GAP spaces events.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    onehot_d = 8'd1 << mem[rd_ptr];
                    cnt_d    = 16'(HOLD_CYCLES - 1);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    onehot_d = '0;
                    cnt_d    = 16'(GAP_CYCLES - 1);
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            GAP: begin
                onehot_d = '0;
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 16'd1;
            end
            default: begin
                onehot_d = '0;
                state_d  = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_event_code_decoder.sv
// Scoreboard bench: stimulus pushes expected pulse values, a monitor pops and
// checks each pulse's value, hold length and (when enabled) back-to-back gap.
module tb_event_code_decoder;
    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = '0;
    logic       in_ready;
    logic [7:0] out_onehot;
    logic       busy;
    logic [2:0] level;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int  ovf_seen = 0;
    bit  chk_gap  = 1'b0;

    event_code_decoder #(.DEPTH(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
        .in_ready(in_ready), .out_onehot(out_onehot), .busy(busy),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: tracks pulses on the falling edge, away from DUT updates.
    bit in_pulse = 1'b0;
    bit have_prev = 1'b0;
    int hold_cnt = 0;
    int low_cnt  = 0;
    always @(negedge clk) begin
        if (rst) begin
            in_pulse  = 1'b0;
            have_prev = 1'b0;
            hold_cnt  = 0;
            low_cnt   = 0;
        end else begin
            if (overflow) ovf_seen++;
            if (out_onehot != 8'h00) begin
                if (!in_pulse) begin
                    if (have_prev && chk_gap) chk("gap_low_cycles", low_cnt, GAP + 1);
                    chk("onehot_bits", $countones(out_onehot), 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", int'(out_onehot), 0);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        chk("pulse_value", int'(out_onehot), int'(e));
                    end
                    in_pulse = 1'b1;
                    hold_cnt = 1;
                end else begin
                    hold_cnt++;
                end
            end else begin
                if (in_pulse) begin
                    chk("hold_cycles", hold_cnt, HOLD);
                    in_pulse  = 1'b0;
                    have_prev = 1'b1;
                    low_cnt   = 1;
                end else begin
                    low_cnt++;
                end
            end
        end
    end

    // One cycle of stimulus: inputs held across the next rising edge.
    task automatic drive(input logic v, input logic [2:0] c);
        in_valid = v;
        in_code  = c;
        @(negedge clk);
    endtask

    task automatic push(input logic [2:0] c);
        exp_q.push_back(8'd1 << c);
        drive(1'b1, c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            drive(1'b0, 3'd0);
            n++;
        end
        chk({nm, "_drain_timeout"}, int'(n >= 200), 0);
        chk({nm, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int o0;
        do_reset();
        chk("rst_out", int'(out_onehot), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);

        // 1: single code 5
        push(3'd5);                      // edge 0
        chk("t1_out_c1", int'(out_onehot), 0);
        drive(1'b0, 3'd0);               // edge 1: pop
        chk("t1_out_c2", int'(out_onehot), 8'h20);
        repeat (5) drive(1'b0, 3'd0);    // edges 2..6
        chk("t1_busy_c7", int'(busy), 1);
        repeat (2) drive(1'b0, 3'd0);    // edges 7..8
        chk("t1_busy_idle", int'(busy), 0);
        drain("t1");

        // 2: three back-to-back codes, gap checked
        do_reset();
        chk_gap = 1'b1;
        o0 = ovf_seen;
        push(3'd1); push(3'd2); push(3'd3);
        drain("t2");
        chk("t2_no_ovf", ovf_seen - o0, 0);

        // 3: overfill by one
        do_reset();
        o0 = ovf_seen;
        for (int i = 0; i < 5; i++) push(3'(i));
        chk("t3_level_full", int'(level), 4);
        chk("t3_ready_low", int'(in_ready), 0);
        drive(1'b1, 3'd5);               // dropped
        chk("t3_ovf_pulse", int'(overflow), 1);
        chk("t3_level_hold", int'(level), 4);
        drive(1'b0, 3'd0);
        chk("t3_ovf_clear", int'(overflow), 0);
        drain("t3");
        chk("t3_ovf_count", ovf_seen - o0, 1);

        // 4: reset mid-pulse with entries queued
        do_reset();
        chk_gap = 1'b0;
        push(3'd1); push(3'd2); push(3'd3);
        chk("t4_level_pre", int'(level), 2);
        rst = 1'b1;
        drive(1'b0, 3'd0);
        exp_q.delete();
        chk("t4_out", int'(out_onehot), 0);
        chk("t4_level", int'(level), 0);
        chk("t4_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (20) drive(1'b0, 3'd0);
        chk("t4_quiet_busy", int'(busy), 0);

        // 5: twelve codes paced one per 8 cycles, pointers wrap
        do_reset();
        o0 = ovf_seen;
        for (int i = 0; i < 12; i++) begin
            push(3'((7 - i) & 7));
            repeat (7) drive(1'b0, 3'd0);
        end
        drain("t5");
        chk("t5_no_ovf", ovf_seen - o0, 0);

        // 6: push refused while full even though the FSM pops that cycle
        do_reset();
        chk_gap = 1'b1;
        o0 = ovf_seen;
        for (int i = 0; i < 5; i++) push(3'(i));   // edges 0..4
        repeat (3) drive(1'b0, 3'd0);               // edges 5..7, back to IDLE
        chk("t6_ready_low", int'(in_ready), 0);
        drive(1'b1, 3'd7);                          // edge 8: pop + refused push
        chk("t6_ovf", int'(overflow), 1);
        chk("t6_level", int'(level), 3);
        drain("t6");
        chk("t6_ovf_count", ovf_seen - o0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
